// File: rtl/i8085_pkg.sv
// Shared types for the 8085 bus responder: FSM states, bus-cycle kinds, wait-state limit.
package i8085_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR
    } bus_cycle_t;

    localparam int WAIT_STATES_MAX = 7;

    function automatic bus_cycle_t cycle_of(input logic io, input logic rd);
        case ({io, rd})
            2'b01:   return MEM_RD;
            2'b00:   return MEM_WR;
            2'b11:   return IO_RD;
            default: return IO_WR;
        endcase
    endfunction

    function automatic logic is_read(input bus_cycle_t c);
        return (c == MEM_RD) || (c == IO_RD);
    endfunction

endpackage

// File: rtl/i8085_resp_ram.sv
// Byte-wide RAM behind the responder: synchronous write port, registered read port.
module i8085_resp_ram
    import i8085_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/i8085_bus_responder.sv
// 8085 multiplexed-bus memory responder with programmable wait states.
// Define I8085_RESP_IO_EN to also map a 4-byte I/O register file at IO_BASE.
module i8085_bus_responder
    import i8085_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  IO_BASE     = 8'h40
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic [7:0] ad_in,
    input  logic [7:0] a_hi,
    input  logic       ale,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       io_m,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ready
);

    localparam int WS_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [2:0] WS_LOAD = 3'(WS_EFF - 1);
`ifdef I8085_RESP_IO_EN
    localparam logic IO_EN = 1'b1;
`else
    localparam logic IO_EN = 1'b0;
`endif

    state_t     state, state_nxt;
    bus_cycle_t cyc_q, cyc_nxt;
    logic [2:0] wait_cnt, cnt_nxt;
    logic [15:0] addr_q;
    logic       io_q;
    logic       hit_q;
    logic [7:0] wdata_q;

    logic [15:0] new_addr;
    logic [16:0] mem_off_new;
    logic [8:0]  io_off_new;
    logic        new_hit;
    logic        wr_commit;
    logic [7:0]  ram_rdata;
    logic [7:0]  io_rdata;
    logic [7:0]  rd_data;

    // Address decode for the cycle being latched; a negative offset wraps into the upper bits.
    assign new_addr    = {a_hi, ad_in};
    assign mem_off_new = {1'b0, new_addr} - {1'b0, BASE_ADDR};
    assign io_off_new  = {1'b0, ad_in} - {1'b0, IO_BASE};
    assign new_hit     = io_m ? (IO_EN && ((io_off_new >> 2) == 9'd0))
                              : ((mem_off_new >> ADDR_BITS) == 17'd0);

    // A write lands only when the strobe is seen released in WRITE, never on abort or reset.
    assign wr_commit = !reset && !ale && (state == ST_WRITE) && wr_n;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        cyc_nxt   = cyc_q;
        if (ale) begin
            state_nxt = ST_ADDR;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (!hit_q) begin
                        state_nxt = ST_DONE;
                    end else if (!rd_n || !wr_n) begin
                        cyc_nxt = cycle_of(io_q, !rd_n);
                        if (WS_EFF == 0) begin
                            state_nxt = !rd_n ? ST_READ : ST_WRITE;
                        end else begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state_nxt = is_read(cyc_q) ? ST_READ : ST_WRITE;
                    end else begin
                        cnt_nxt = wait_cnt - 3'd1;
                    end
                end
                ST_READ:  if (rd_n) state_nxt = ST_IDLE;
                ST_WRITE: if (wr_n) state_nxt = ST_IDLE;
                ST_DONE:  if (rd_n && wr_n) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state    <= ST_IDLE;
            cyc_q    <= MEM_RD;
            wait_cnt <= 3'd0;
            addr_q   <= 16'h0000;
            io_q     <= 1'b0;
            hit_q    <= 1'b0;
            ad_out   <= 8'h00;
            ad_oe    <= 1'b0;
            ready    <= 1'b1;
        end else begin
            state    <= state_nxt;
            cyc_q    <= cyc_nxt;
            wait_cnt <= cnt_nxt;
            if (ale) begin
                addr_q <= new_addr;
                io_q   <= io_m;
                hit_q  <= new_hit;
            end
            ad_oe  <= (state_nxt == ST_READ);
            ready  <= (state_nxt != ST_WAIT);
            ad_out <= (state_nxt == ST_READ) ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge clk_out) begin
        if (!wr_n && !ale) begin
            wdata_q <= ad_in;
        end
    end

    // Read address follows the bus during ALE so data is ready by the first READ cycle.
    i8085_resp_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (clk_out),
        .we    (wr_commit && !io_q),
        .waddr (ADDR_BITS'(addr_q - BASE_ADDR)),
        .wdata (wdata_q),
        .raddr (ale ? ADDR_BITS'(new_addr - BASE_ADDR) : ADDR_BITS'(addr_q - BASE_ADDR)),
        .rdata (ram_rdata)
    );

`ifdef I8085_RESP_IO_EN
    logic [7:0] io_regs [4];
    logic [1:0] io_idx;

    assign io_idx   = 2'(addr_q[7:0] - IO_BASE);
    assign io_rdata = io_regs[io_idx];

    always_ff @(posedge clk_out) begin
        if (wr_commit && io_q) begin
            io_regs[io_idx] <= wdata_q;
        end
    end
`else
    assign io_rdata = 8'h00;
`endif

    assign rd_data = io_q ? io_rdata : ram_rdata;

endmodule
